// File: rtl/niossoc_pio_pkg.sv
// Shared constants for the Nios II PIO slaves: register word addresses
// and the edge-selection codes used by the input PIO.
package niossoc_pio_pkg;

    localparam logic [1:0] PIO_DATA     = 2'd0;
    localparam logic [1:0] PIO_RESERVED = 2'd1;
    localparam logic [1:0] PIO_IRQMASK  = 2'd2;
    localparam logic [1:0] PIO_EDGECAP  = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/niossoc_sync_bus.sv
// Multi-flop synchroniser for a bus of independent asynchronous inputs.
// Each bit passes through STAGES flops; every stage resets to 0.
module niossoc_sync_bus #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the raw inputs down the flop chain, clearing it on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_out = stage_q[STAGES-1];

endmodule

// File: rtl/niossoc_pio_in.sv
// Avalon-MM input PIO: synchronises an external bus, exposes its live
// value, captures selected edges into a sticky W1C register and raises
// a level interrupt when any captured edge is unmasked.
module niossoc_pio_in
    import niossoc_pio_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int         WARM_COUNT = SYNC_STAGES + 1;
    localparam logic [2:0] WARM_MAX   = 3'(WARM_COUNT);

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] prev;
    logic [2:0]       warm_cnt;
    logic             warm_done;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic             wr;
    logic             unused_writedata;

    niossoc_sync_bus #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (in_port),
        .sync_out (sync_out)
    );

    assign wr               = chipselect & ~write_n;
    assign warm_done        = (warm_cnt == WARM_MAX);
    assign unused_writedata = ^writedata;

    // Keep the previous synchronised value so edges can be seen
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= sync_out;
        end
    end

    // Hold off edge detection until the synchroniser and prev have filled,
    // so an input already high at reset is not taken for a rising edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt <= '0;
        end else if (!warm_done) begin
            warm_cnt <= warm_cnt + 3'd1;
        end
    end

    // Select which transitions count as edges and form the W1C clear mask
    always_comb begin
        rise = sync_out & ~prev;
        fall = ~sync_out & prev;
        det  = '0;
        if (warm_done) begin
            case (EDGE_TYPE)
                EDGE_FALL: det = fall;
                EDGE_ANY:  det = rise | fall;
                default:   det = rise;
            endcase
        end
        clr = '0;
        if (wr && (address == PIO_EDGECAP)) begin
            clr = writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture; a new edge wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~clr) | det;
        end
    end

    // Interrupt mask register, written directly by the CPU
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr && (address == PIO_IRQMASK)) begin
            irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Zero-wait-state read mux; unused upper bits read as zero
    always_comb begin
        readdata = '0;
        case (address)
            PIO_DATA:     readdata[WIDTH-1:0] = sync_out;
            PIO_RESERVED: readdata = '0;
            PIO_IRQMASK:  readdata[WIDTH-1:0] = irqmask;
            PIO_EDGECAP:  readdata[WIDTH-1:0] = edgecap;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_niossoc_pio_in.sv
// Testbench for niossoc_pio_in: a rising-edge and an any-edge instance
// share one bus; a sample-history model predicts both every cycle.
module tb_niossoc_pio_in;
    import niossoc_pio_pkg::*;

    localparam int W = 4;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] readdata_rise;
    logic [31:0] readdata_any;
    logic        irq_rise;
    logic        irq_any;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    niossoc_pio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(EDGE_RISE)) dut_rise (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata_rise),
        .in_port    (in_port),
        .irq        (irq_rise)
    );

    niossoc_pio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(EDGE_ANY)) dut_any (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata_any),
        .in_port    (in_port),
        .irq        (irq_any)
    );

    // Model: hist[k] is the raw input sampled k edges ago; the visible value
    // lags the samples by S-1 edges and edges only count once warmed up
    logic [W-1:0] hist [0:7];
    int           edges;
    logic [W-1:0] m_mask;
    logic [W-1:0] m_cap_rise;
    logic [W-1:0] m_cap_any;

    // Advance the model on every clock edge, clear it on reset
    always @(posedge clk or negedge reset_n) begin
        logic [W-1:0] now_v;
        logic [W-1:0] old_v;
        logic [W-1:0] up;
        logic [W-1:0] down;
        logic [W-1:0] clr;
        logic         warm;
        logic         wr;
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) hist[i] <= '0;
            edges      <= 0;
            m_mask     <= '0;
            m_cap_rise <= '0;
            m_cap_any  <= '0;
        end else begin
            now_v = hist[S-1];
            old_v = hist[S];
            warm  = (edges >= S + 1);
            up    = warm ? (now_v & ~old_v) : '0;
            down  = warm ? (~now_v & old_v) : '0;
            wr    = chipselect && !write_n;
            clr   = (wr && address == PIO_EDGECAP) ? writedata[W-1:0] : '0;
            m_cap_rise <= (m_cap_rise & ~clr) | up;
            m_cap_any  <= (m_cap_any & ~clr) | up | down;
            if (wr && address == PIO_IRQMASK) m_mask <= writedata[W-1:0];
            hist[0] <= in_port;
            for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
            if (edges < 1000) edges <= edges + 1;
        end
    end

    function automatic logic [31:0] modelRead(input logic [1:0] a, input logic [W-1:0] cap);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[W-1:0] = hist[S-1];
            2'd2: r[W-1:0] = m_mask;
            2'd3: r[W-1:0] = cap;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Compare both instances against the model on every falling edge
    always @(negedge clk) begin
        checkOutput("model_rd_rise", readdata_rise, modelRead(address, m_cap_rise));
        checkOutput("model_rd_any", readdata_any, modelRead(address, m_cap_any));
        checkOutput("model_irq_rise", {31'b0, irq_rise}, {31'b0, |(m_cap_rise & m_mask)});
        checkOutput("model_irq_any", {31'b0, irq_any}, {31'b0, |(m_cap_any & m_mask)});
    end

    // Drive one bus cycle and return 2ns after the edge that sampled it
    task automatic applyStimulus(input logic cs, input logic wn, input logic [1:0] addr,
                                 input logic [31:0] wd, input logic [W-1:0] inp);
        chipselect = cs;
        write_n    = wn;
        address    = addr;
        writedata  = wd;
        in_port    = inp;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, address, 32'h0, in_port);
    endtask

    task automatic readCheck(input string name, input logic [1:0] addr,
                             input logic [31:0] exp_rise, input logic [31:0] exp_any);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = addr;
        #1;
        checkOutput({name, "_rise"}, readdata_rise, exp_rise);
        checkOutput({name, "_any"}, readdata_any, exp_any);
    endtask

    task automatic irqCheck(input string name, input logic exp_rise, input logic exp_any);
        checkOutput({name, "_rise"}, {31'b0, irq_rise}, {31'b0, exp_rise});
        checkOutput({name, "_any"}, {31'b0, irq_any}, {31'b0, exp_any});
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        in_port    = 4'hF;
        #1;
        irqCheck("reset_irq", 1'b0, 1'b0);
        readCheck("reset_data", 2'd0, 32'h0, 32'h0);
        readCheck("reset_rsvd", 2'd1, 32'h0, 32'h0);
        readCheck("reset_mask", 2'd2, 32'h0, 32'h0);
        readCheck("reset_cap", 2'd3, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Input high through reset must not be captured
        idle(10);
        readCheck("warm_cap", 2'd3, 32'h0, 32'h0);
        readCheck("warm_data", 2'd0, 32'hF, 32'hF);
        irqCheck("warm_irq", 1'b0, 1'b0);

        // Drop all inputs, then clear captures and set mask back-to-back
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 4'h0);
        idle(4);
        readCheck("fall_cap", 2'd3, 32'h0, 32'hF);
        applyStimulus(1'b1, 1'b0, 2'd3, 32'hF, 4'h0);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1, 4'h0);
        readCheck("b2b_cap", 2'd3, 32'h0, 32'h0);
        readCheck("b2b_mask", 2'd2, 32'h1, 32'h1);

        // Rising edge on bit0: latency through synchroniser and capture
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 4'h1);
        readCheck("lat_data_k", 2'd0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 4'h1);
        readCheck("lat_data_k1", 2'd0, 32'h1, 32'h1);
        readCheck("lat_cap_k1", 2'd3, 32'h0, 32'h0);
        irqCheck("lat_irq_k1", 1'b0, 1'b0);
        idle(1);
        readCheck("lat_cap_k2", 2'd3, 32'h1, 32'h1);
        irqCheck("lat_irq_k2", 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'd3, 32'h1, 4'h1);
        readCheck("w1c_cap", 2'd3, 32'h0, 32'h0);
        irqCheck("w1c_irq", 1'b0, 1'b0);

        // Edge on bit2 arrives on the same edge as its W1C clear
        applyStimulus(1'b0, 1'b1, 2'd3, 32'h0, 4'h5);
        applyStimulus(1'b0, 1'b1, 2'd3, 32'h0, 4'h5);
        applyStimulus(1'b1, 1'b0, 2'd3, 32'h4, 4'h5);
        readCheck("setwins_cap", 2'd3, 32'h4, 32'h4);
        irqCheck("setwins_irq", 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd3, 32'h4, 4'h5);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h0, 4'h5);
        readCheck("clear2_cap", 2'd3, 32'h0, 32'h0);

        // Pulse bit1 high for 3 clocks with mask 0, then unmask it
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 4'h7);
        idle(2);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 4'h5);
        idle(4);
        readCheck("pulse_cap", 2'd3, 32'h2, 32'h2);
        irqCheck("pulse_irq_masked", 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h2, 4'h5);
        irqCheck("pulse_irq_unmasked", 1'b1, 1'b1);

        // Falling edge on bit0 is seen only by the any-edge instance
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 4'h4);
        idle(3);
        readCheck("fallonly_cap", 2'd3, 32'h2, 32'h3);

        // Register map: masked width, read-only DATA, reserved word
        applyStimulus(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 4'h4);
        readCheck("mask_width", 2'd2, 32'hF, 32'hF);
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'h4);
        readCheck("data_ro", 2'd0, 32'h4, 32'h4);
        readCheck("rsvd", 2'd1, 32'h0, 32'h0);

        // Build EDGECAP=0xA on the rising instance, then reset mid-run
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 4'hC);
        idle(3);
        readCheck("pre_reset_cap", 2'd3, 32'hA, 32'hB);
        irqCheck("pre_reset_irq", 1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        irqCheck("async_reset_irq", 1'b0, 1'b0);
        readCheck("async_reset_data", 2'd0, 32'h0, 32'h0);
        readCheck("async_reset_mask", 2'd2, 32'h0, 32'h0);
        readCheck("async_reset_cap", 2'd3, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        idle(6);
        readCheck("rewarm_data", 2'd0, 32'hC, 32'hC);
        readCheck("rewarm_cap", 2'd3, 32'h0, 32'h0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
